// File: rtl/voice_allocator.sv
// Note-event to voice allocator in front of the adsr bank: retrigger > idle > releasing > steal-oldest.
// Optional VOICE_ALLOC_STEAL_EN enables stealing; without it a note-on that finds every voice busy is dropped.
module voice_allocator #(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7,
  parameter int VEL_BITS  = 7,
  parameter int AGE_BITS  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [NOTE_BITS-1:0]          ev_note,
  input  logic [VEL_BITS-1:0]           ev_velocity,
  input  logic [VOICES-1:0]             active,
  output logic [VOICES-1:0]             gate,
  output logic [VOICES*NOTE_BITS-1:0]   note,
  output logic [VOICES*VEL_BITS-1:0]    velocity
);
  localparam int TW = $clog2(VOICES);

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_ASSERT} state_e;

  state_e                             state_q, state_d;
  logic                               rdy_q;
  logic                               on_q, on_d;
  logic [NOTE_BITS-1:0]               evn_q, evn_d;
  logic [VEL_BITS-1:0]                evv_q, evv_d;
  logic [TW-1:0]                      tgt_q, tgt_d;
  logic [VOICES-1:0]                  gate_q, gate_d;
  logic [VOICES*NOTE_BITS-1:0]        note_q, note_d;
  logic [VOICES*VEL_BITS-1:0]         vel_q, vel_d;
  logic [VOICES-1:0][AGE_BITS-1:0]    age_q, age_d;

  logic [VOICES-1:0]                  same, idle, free;
  logic [TW-1:0]                      oldest, sel;
  logic [AGE_BITS-1:0]                best;
  logic                               take;

  function automatic logic [TW-1:0] lowest(input logic [VOICES-1:0] v);
    lowest = '0;
    for (int i = VOICES-1; i >= 0; i--) begin
      if (v[i]) lowest = TW'(i);
    end
  endfunction

  // rdy_q holds ev_ready low until the first edge after reset is released
  assign ev_ready = rdy_q && (state_q == S_IDLE);
  assign gate     = gate_q;
  assign note     = note_q;
  assign velocity = vel_q;

  always_comb begin
    same   = '0;
    oldest = '0;
    best   = '0;
    for (int i = 0; i < VOICES; i++) begin
      same[i] = gate_q[i] && (note_q[i*NOTE_BITS +: NOTE_BITS] == evn_q);
      if (gate_q[i] && (age_q[i] > best)) begin
        best   = age_q[i];
        oldest = TW'(i);
      end
    end
    free = ~gate_q;
    idle = ~gate_q & ~active;
    if (|same)      sel = lowest(same);
    else if (|idle) sel = lowest(idle);
    else if (|free) sel = lowest(free);
    else            sel = oldest;
`ifdef VOICE_ALLOC_STEAL_EN
    take = 1'b1;
`else
    take = (|same) || (|free);
`endif
  end

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    evn_d   = evn_q;
    evv_d   = evv_q;
    tgt_d   = tgt_q;
    gate_d  = gate_q;
    note_d  = note_q;
    vel_d   = vel_q;
    age_d   = age_q;
    case (state_q)
      S_IDLE: begin
        if (ev_valid && ev_ready) begin
          on_d    = ev_on;
          evn_d   = ev_note;
          evv_d   = ev_velocity;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        state_d = S_IDLE;
        if (!on_q) begin
          gate_d = gate_q & ~same;
        end else if (take) begin
          tgt_d = sel;
          note_d[sel*NOTE_BITS +: NOTE_BITS] = evn_q;
          vel_d[sel*VEL_BITS +: VEL_BITS]    = evv_q;
          for (int i = 0; i < VOICES; i++) begin
            if (TW'(i) == sel)       age_d[i] = '0;
            else if (age_q[i] != '1) age_d[i] = age_q[i] + 1'b1;
          end
          // a voice already gated needs one low cycle so the adsr sees a new rising edge
          if (gate_q[sel]) begin
            gate_d[sel] = 1'b0;
            state_d     = S_ASSERT;
          end else begin
            gate_d[sel] = 1'b1;
          end
        end
      end
      S_ASSERT: begin
        gate_d[tgt_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      on_q    <= 1'b0;
      evn_q   <= '0;
      evv_q   <= '0;
      tgt_q   <= '0;
      gate_q  <= '0;
      note_q  <= '0;
      vel_q   <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      on_q    <= on_d;
      evn_q   <= evn_d;
      evv_q   <= evv_d;
      tgt_q   <= tgt_d;
      gate_q  <= gate_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      age_q   <= age_d;
    end
  end
endmodule
